// File: rtl/arith_pkg.sv
// Shared Q1.7 arithmetic definitions: widths, saturation limits, divider FSM states and saturation helper.
package arith_pkg;

   localparam int DATA_W    = 8;
   localparam int FRAC_BITS = 7;
   localparam int QUOT_W    = DATA_W + FRAC_BITS;
   localparam int REM_W     = DATA_W + 1;
   localparam int CNT_W     = $clog2(QUOT_W);

   localparam logic signed [DATA_W-1:0] Q_MIN = 8'sh80;
   localparam logic signed [DATA_W-1:0] Q_MAX = 8'sh7F;

   typedef enum logic {IDLE, CALC} div_state_t;

   // Applies the sign to an unsigned magnitude, clamping to the Q1.7 range.
   function automatic logic signed [DATA_W-1:0] sat_q17(input logic [QUOT_W:0] mag, input logic neg);
      logic [DATA_W-1:0] w_low;
      w_low = mag[DATA_W-1:0];
      if (neg) begin
         if (mag >= (QUOT_W+1)'(128)) return Q_MIN;
         return $signed(DATA_W'(0) - w_low);
      end
      if (mag >= (QUOT_W+1)'(127)) return Q_MAX;
      return $signed(w_low);
   endfunction

endpackage

// File: rtl/arithmetic_divider_if.sv
// Operand/result bundle of the Q1.7 divider; master drives operands, slave returns results.
interface arithmetic_divider_if;
   import arith_pkg::*;

   logic                     i_valid;
   logic                     o_ready;
   logic signed [DATA_W-1:0] i_data_a;
   logic signed [DATA_W-1:0] i_data_b;
   logic signed [DATA_W-1:0] o_data;
   logic                     o_valid;
   logic                     o_div_zero;

   modport master (
      output i_valid, i_data_a, i_data_b,
      input  o_ready, o_data, o_valid, o_div_zero
   );

   modport slave (
      input  i_valid, i_data_a, i_data_b,
      output o_ready, o_data, o_valid, o_div_zero
   );

endinterface

// File: rtl/arithmetic_divider_div_restore_step.sv
// One restoring-division iteration: shift a dividend bit into the remainder, subtract the divisor if it fits.
module div_restore_step
   import arith_pkg::*;
(
   input  logic [REM_W-1:0]  i_rem,
   input  logic              i_bit,
   input  logic [DATA_W-1:0] i_divisor,
   output logic [REM_W-1:0]  o_rem,
   output logic              o_q_bit
);

   logic [REM_W:0] w_shift;
   logic [REM_W:0] w_div_ext;
   logic [REM_W:0] w_diff;

   assign w_shift   = {i_rem, i_bit};
   assign w_div_ext = {2'b00, i_divisor};
   assign w_diff    = w_shift - w_div_ext;
   assign o_q_bit   = (w_shift >= w_div_ext);
   // The remainder stays below the divisor (<=128), so the top bit is always zero.
   assign o_rem     = REM_W'(o_q_bit ? w_diff : w_shift);

endmodule

// File: rtl/arithmetic_divider.sv
// Sequential Q1.7 signed divider, o_data = sat((A<<7)/B), fixed 15-cycle latency, accepts only while o_ready.
// Build option ROUND_NEAREST_EN: round the magnitude to nearest instead of truncating.
module arithmetic_divider
   import arith_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   arithmetic_divider_if.slave bus
);

   div_state_t               r_state;
   div_state_t               w_next_state;
   logic [CNT_W-1:0]         r_cnt;
   logic [QUOT_W-1:0]        r_dvd;
   logic [QUOT_W-2:0]        r_quot;
   logic [DATA_W-1:0]        r_div;
   logic [REM_W-1:0]         r_rem;
   logic                     r_neg;
   logic                     r_a_neg;
   logic                     r_zero;
   logic signed [DATA_W-1:0] r_data;
   logic                     r_valid;
   logic                     r_div_zero;

   logic                     w_ready;
   logic                     w_accept;
   logic                     w_last;
   logic [DATA_W-1:0]        w_abs_a;
   logic [DATA_W-1:0]        w_abs_b;
   logic [REM_W-1:0]         w_rem_out;
   logic                     w_qbit;
   logic [QUOT_W-1:0]        w_q_final;
   logic [QUOT_W:0]          w_mag;

   // |-128| = 128 still fits the unsigned DATA_W magnitude.
   assign w_abs_a = bus.i_data_a[DATA_W-1] ? DATA_W'(-bus.i_data_a) : bus.i_data_a;
   assign w_abs_b = bus.i_data_b[DATA_W-1] ? DATA_W'(-bus.i_data_b) : bus.i_data_b;

   div_restore_step u_step (
      .i_rem     (r_rem),
      .i_bit     (r_dvd[QUOT_W-1]),
      .i_divisor (r_div),
      .o_rem     (w_rem_out),
      .o_q_bit   (w_qbit)
   );

   assign w_q_final = {r_quot, w_qbit};

`ifdef ROUND_NEAREST_EN
   logic w_round_up;
   assign w_round_up = ({w_rem_out, 1'b0} >= {2'b00, r_div});
   assign w_mag      = {1'b0, w_q_final} + (QUOT_W+1)'(w_round_up);
`else
   assign w_mag      = {1'b0, w_q_final};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next_state = CALC;
         CALC:    if (w_last)   w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      w_ready  = (r_state == IDLE);
      w_accept = w_ready && bus.i_valid;
      w_last   = (r_state == CALC) && (r_cnt == CNT_W'(QUOT_W-1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= '0;
         r_dvd      <= '0;
         r_quot     <= '0;
         r_div      <= '0;
         r_rem      <= '0;
         r_neg      <= 1'b0;
         r_a_neg    <= 1'b0;
         r_zero     <= 1'b0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_accept) begin
            r_dvd   <= {w_abs_a, {FRAC_BITS{1'b0}}};
            r_div   <= w_abs_b;
            r_neg   <= bus.i_data_a[DATA_W-1] ^ bus.i_data_b[DATA_W-1];
            r_a_neg <= bus.i_data_a[DATA_W-1];
            r_zero  <= (bus.i_data_b == '0);
            r_rem   <= '0;
            r_quot  <= '0;
            r_cnt   <= '0;
         end else if (r_state == CALC) begin
            r_dvd  <= {r_dvd[QUOT_W-2:0], 1'b0};
            r_rem  <= w_rem_out;
            r_quot <= w_q_final[QUOT_W-2:0];
            r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
               r_valid    <= 1'b1;
               r_div_zero <= r_zero;
               r_data     <= r_zero ? (r_a_neg ? Q_MIN : Q_MAX) : sat_q17(w_mag, r_neg);
            end
         end
      end
   end

   assign bus.o_ready    = w_ready;
   assign bus.o_valid    = r_valid;
   assign bus.o_data     = r_data;
   assign bus.o_div_zero = r_div_zero;

endmodule

// File: tb/tb_arithmetic_divider.sv
// Bench for arithmetic_divider: table vectors, model-checked random pairs, back-to-back and reset-abort sequences.
module tb_arithmetic_divider;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   arithmetic_divider_if u_if();

   arithmetic_divider u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   typedef struct {
      logic signed [7:0] a;
      logic signed [7:0] b;
      logic signed [7:0] exp_q;
      logic              exp_z;
      string             name;
   } vec_t;

   typedef struct {
      logic signed [7:0] exp_q;
      logic              exp_z;
      int                t_acc;
      string             name;
   } sb_t;

`ifdef ROUND_NEAREST_EN
   localparam logic signed [7:0] Q_ONE_THIRD = 8'sd43;
`else
   localparam logic signed [7:0] Q_ONE_THIRD = 8'sd42;
`endif

   sb_t               sb[$];
   vec_t              vecs[13];
   int                n_checks   = 0;
   int                n_fail     = 0;
   int                cyc        = 0;
   int                n_acc      = 0;
   int                n_pulse    = 0;
   int                last_acc   = 0;
   int                last_pulse = 0;
   logic signed [7:0] cur_q;
   logic              cur_z;
   string             cur_name;

   task automatic chk(input string nm, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   task automatic model(input logic signed [7:0] a, input logic signed [7:0] b,
                        output logic signed [7:0] q, output logic z);
      int ai, bi, ma, mb, qq;
      ai = int'(a);
      bi = int'(b);
      ma = (ai < 0) ? -ai : ai;
      mb = (bi < 0) ? -bi : bi;
      z  = (bi == 0);
      if (z) begin
         q = (ai < 0) ? 8'sh80 : 8'sh7F;
      end else begin
         qq = (ma * 128) / mb;
`ifdef ROUND_NEAREST_EN
         if (2 * ((ma * 128) % mb) >= mb) qq++;
`endif
         if ((ai < 0) != (bi < 0)) q = 8'((qq > 128) ? -128 : -qq);
         else                      q = 8'((qq > 127) ? 127 : qq);
      end
   endtask

   // One clock: register an accept before the edge, check any result after it.
   task automatic step();
      sb_t e;
      if (!rst && u_if.i_valid && u_if.o_ready) begin
         e.exp_q = cur_q;
         e.exp_z = cur_z;
         e.t_acc = cyc + 1;
         e.name  = cur_name;
         sb.push_back(e);
         n_acc++;
         last_acc = cyc + 1;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (rst) begin
         sb.delete();
      end else if (u_if.o_valid) begin
         n_pulse++;
         last_pulse = cyc;
         if (sb.size() == 0) begin
            chk("spurious_o_valid", int'(u_if.o_valid), 0);
         end else begin
            e = sb.pop_front();
            chk({"data_", e.name}, int'(u_if.o_data), int'(e.exp_q));
            chk({"divzero_", e.name}, int'(u_if.o_div_zero), int'(e.exp_z));
            chk({"latency_", e.name}, cyc - e.t_acc, 15);
         end
      end
   endtask

   task automatic set_op(input logic signed [7:0] a, input logic signed [7:0] b, input string nm);
      u_if.i_data_a = a;
      u_if.i_data_b = b;
      model(a, b, cur_q, cur_z);
      cur_name = nm;
   endtask

   task automatic run_op(input vec_t v);
      for (int i = 0; i < 40 && !u_if.o_ready; i++) step();
      u_if.i_data_a = v.a;
      u_if.i_data_b = v.b;
      cur_q         = v.exp_q;
      cur_z         = v.exp_z;
      cur_name      = v.name;
      u_if.i_valid  = 1'b1;
      step();
      u_if.i_valid  = 1'b0;
      for (int i = 0; i < 40 && sb.size() != 0; i++) step();
      chk({"done_", v.name}, sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int   p1, n0, np, g;
      vec_t rv;

      vecs[0]  = '{8'sd32,  8'sd64,  8'sd64,       1'b0, "32_div_64"};
      vecs[1]  = '{8'sd64,  8'sh80,  -8'sd64,      1'b0, "64_div_m128"};
      vecs[2]  = '{-8'sd64, 8'sd32,  8'sh80,       1'b0, "m64_div_32"};
      vecs[3]  = '{8'sd64,  8'sd32,  8'sh7F,       1'b0, "64_div_32"};
      vecs[4]  = '{8'sh80,  8'sh80,  8'sh7F,       1'b0, "m128_div_m128"};
      vecs[5]  = '{8'sd1,   8'sd3,   Q_ONE_THIRD,  1'b0, "1_div_3"};
      vecs[6]  = '{-8'sd1,  8'sd3,   -Q_ONE_THIRD, 1'b0, "m1_div_3"};
      vecs[7]  = '{8'sd5,   8'sd0,   8'sh7F,       1'b1, "5_div_0"};
      vecs[8]  = '{-8'sd5,  8'sd0,   8'sh80,       1'b1, "m5_div_0"};
      vecs[9]  = '{8'sd0,   8'sd5,   8'sd0,        1'b0, "0_div_5"};
      vecs[10] = '{8'sd0,   8'sd0,   8'sh7F,       1'b1, "0_div_0"};
      vecs[11] = '{8'sd127, 8'sd127, 8'sh7F,       1'b0, "127_div_127"};
      vecs[12] = '{8'sh80,  8'sd127, 8'sh80,       1'b0, "m128_div_127"};

      rst           = 1'b1;
      u_if.i_valid  = 1'b0;
      u_if.i_data_a = '0;
      u_if.i_data_b = '0;
      cur_q         = '0;
      cur_z         = 1'b0;
      cur_name      = "none";
      #1;
      chk("reset_o_ready",    int'(u_if.o_ready),    1);
      chk("reset_o_valid",    int'(u_if.o_valid),    0);
      chk("reset_o_data",     int'(u_if.o_data),     0);
      chk("reset_o_div_zero", int'(u_if.o_div_zero), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      step();

      foreach (vecs[i]) run_op(vecs[i]);

      for (int i = 0; i < 8; i++) begin
         rv.a    = 8'($urandom_range(255, 0));
         rv.b    = 8'($urandom_range(255, 0));
         rv.name = $sformatf("rand%0d_%0d_div_%0d", i, rv.a, rv.b);
         model(rv.a, rv.b, rv.exp_q, rv.exp_z);
         run_op(rv);
      end

      // Back-to-back: i_valid held high, second pair taken as soon as the first result appears.
      n0 = n_acc;
      set_op(8'sd32, 8'sd64, "b2b_first");
      u_if.i_valid = 1'b1;
      for (g = 0; g < 5 && n_acc == n0; g++) step();
      set_op(-8'sd64, 8'sd96, "b2b_second");
      for (g = 0; g < 60 && n_acc == n0 + 1; g++) step();
      u_if.i_valid = 1'b0;
      p1 = last_pulse;
      chk("b2b_accepts", n_acc - n0, 2);
      chk("b2b_accept_in_valid_cycle", last_acc - p1, 1);
      for (int i = 0; i < 40 && sb.size() != 0; i++) step();
      chk("b2b_drain", sb.size(), 0);
      sb.delete();

      // Short i_valid pulse during CALC must be ignored.
      set_op(8'sd100, 8'sd50, "calc_ignore");
      u_if.i_valid = 1'b1;
      step();
      u_if.i_valid = 1'b0;
      repeat (5) step();
      n0 = n_acc;
      u_if.i_data_a = 8'sd7;
      u_if.i_valid  = 1'b1;
      step();
      u_if.i_valid  = 1'b0;
      chk("calc_pulse_ignored", n_acc - n0, 0);
      for (int i = 0; i < 40 && sb.size() != 0; i++) step();
      chk("calc_ignore_drain", sb.size(), 0);
      sb.delete();

      // Reset during CALC aborts the operation.
      run_op(vecs[7]);
      set_op(8'sd64, 8'sd3, "aborted");
      u_if.i_valid = 1'b1;
      step();
      u_if.i_valid = 1'b0;
      repeat (7) step();
      rst = 1'b1;
      #1;
      chk("abort_o_ready",    int'(u_if.o_ready),    1);
      chk("abort_o_valid",    int'(u_if.o_valid),    0);
      chk("abort_o_data",     int'(u_if.o_data),     0);
      chk("abort_o_div_zero", int'(u_if.o_div_zero), 0);
      step();
      step();
      rst = 1'b0;
      #1;
      chk("ready_after_release", int'(u_if.o_ready), 1);
      np = n_pulse;
      repeat (25) step();
      chk("no_pulse_after_abort", n_pulse - np, 0);

      run_op(vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
